// File: rtl/resp_2ph_sync_if.sv
// resp_2ph_sync_if: service handshake between the 2-phase responder
// and the synchronous consumer (valid/ready with channel tag).
interface resp_2ph_sync_if;
    logic svc_valid;
    logic svc_ch;
    logic svc_ready;

    modport master (
        output svc_valid,
        output svc_ch,
        input  svc_ready
    );

    modport slave (
        input  svc_valid,
        input  svc_ch,
        output svc_ready
    );
endinterface

// File: rtl/resp_2ph_sync.sv
// resp_2ph_sync: synchronises 2-phase grants g1/g2 into clk, offers
// each as a valid/ready service, and returns a 2-phase done on d1/d2.
module resp_2ph_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            g1,
    input  logic            g2,
    output logic            d1,
    output logic            d2,
    output logic            busy,
    output logic            err,
    resp_2ph_sync_if.master svc
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HOLD,
        DONE
    } state_t;

    localparam bit HAS_HOLD = (HOLD_CYCLES > 0);
    localparam logic [7:0] HOLD_LOAD =
        HAS_HOLD ? 8'(HOLD_CYCLES - 1) : 8'd0;

    logic [SYNC_STAGES-1:0] sync1_q;
    logic [SYNC_STAGES-1:0] sync1_d;
    logic [SYNC_STAGES-1:0] sync2_q;
    logic [SYNC_STAGES-1:0] sync2_d;

    state_t     state_q;
    state_t     state_d;
    logic       ch_q;
    logic       ch_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       seen1_q;
    logic       seen1_d;
    logic       seen2_q;
    logic       seen2_d;
    logic       err_q;
    logic       err_d;

    logic gs1;
    logic gs2;
    logic pend1;
    logic pend2;
    logic pend_cur;
    logic valid;

    assign gs1      = sync1_q[SYNC_STAGES-1];
    assign gs2      = sync2_q[SYNC_STAGES-1];
    assign pend1    = gs1 ^ seen1_q;
    assign pend2    = gs2 ^ seen2_q;
    assign pend_cur = ch_q ? pend2 : pend1;

    // Shift the raw grants into their synchroniser chains.
    always_comb begin
        sync1_d = {sync1_q[SYNC_STAGES-2:0], g1};
        sync2_d = {sync2_q[SYNC_STAGES-2:0], g2};
    end

    // Next-state, service offer and protocol-error detection.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        seen1_d = seen1_q;
        seen2_d = seen2_q;
        err_d   = err_q;
        valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend1 && pend2) begin
                    err_d = 1'b1;
                end
                if (pend1) begin
                    ch_d    = 1'b0;
                    state_d = OFFER;
                end else if (pend2) begin
                    ch_d    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                valid = 1'b1;
                if (!pend_cur) begin
                    err_d = 1'b1;
                end
                if (svc.svc_ready) begin
                    if (HAS_HOLD) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (!pend_cur) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (ch_q) begin
                    seen2_d = ~seen2_q;
                end else begin
                    seen1_d = ~seen1_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            ch_q    <= 1'b0;
            cnt_q   <= 8'd0;
            seen1_q <= 1'b0;
            seen2_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            seen1_q <= seen1_d;
            seen2_q <= seen2_d;
            err_q   <= err_d;
        end
    end

    // d1/d2 come straight from flops: they feed async logic.
    assign d1            = seen1_q;
    assign d2            = seen2_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;
    assign svc.svc_valid = valid;
    assign svc.svc_ch    = ch_q;

endmodule

// File: tb/tb_resp_2ph_sync.sv
// tb_resp_2ph_sync: scoreboard bench for resp_2ph_sync; expected
// services and done-toggle times come from a queue-based model.
module tb_resp_2ph_sync;

    localparam int SYNC  = 2;
    localparam int HOLD  = 3;
    localparam int LAT   = SYNC + HOLD + 3;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g1  = 1'b0;
    logic g2  = 1'b0;
    logic d1;
    logic d2;
    logic busy;
    logic err;

    resp_2ph_sync_if svc_if ();

    resp_2ph_sync #(
        .SYNC_STAGES(SYNC),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .g1  (g1),
        .g2  (g2),
        .d1  (d1),
        .d2  (d2),
        .busy(busy),
        .err (err),
        .svc (svc_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: services expected in grant order, and the cycles at
    // which each channel's done must toggle.
    int exp_q[$];
    int due1[$];
    int due2[$];
    bit dexp1    = 1'b0;
    bit dexp2    = 1'b0;
    bit armed    = 1'b0;
    bit rst_prev = 1'b0;
    bit pv       = 1'b0;
    bit pch      = 1'b0;
    bit pacc     = 1'b0;

    task automatic check(input string name, input int act,
                         input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected services on accept, tracks d timing.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                if (rst_prev) begin
                    dexp1 = 1'b0;
                    dexp2 = 1'b0;
                end
                if (due1.size() > 0 && due1[0] == cyc) begin
                    void'(due1.pop_front());
                    dexp1 = ~dexp1;
                end
                if (due2.size() > 0 && due2[0] == cyc) begin
                    void'(due2.pop_front());
                    dexp2 = ~dexp2;
                end
                check("d1", int'(d1), int'(dexp1));
                check("d2", int'(d2), int'(dexp2));
                if (svc_if.svc_valid && pv && !pacc && !rst_prev)
                    check("ch_stable", int'(svc_if.svc_ch), int'(pch));
                pacc = 1'b0;
                if (!rst && svc_if.svc_valid && svc_if.svc_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_svc", 1, 0);
                    else
                        check("svc_ch", int'(svc_if.svc_ch),
                              exp_q.pop_front());
                    if (svc_if.svc_ch)
                        due2.push_back(cyc + HOLD + 2);
                    else
                        due1.push_back(cyc + HOLD + 2);
                    pacc = 1'b1;
                end
                pv  = svc_if.svc_valid;
                pch = svc_if.svc_ch;
                if (rst) begin
                    due1.delete();
                    due2.delete();
                    exp_q.delete();
                end
                rst_prev = rst;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tog(input int ch);
        if (ch == 0) g1 = ~g1;
        else g2 = ~g2;
        exp_q.push_back(ch);
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        int n = 0;
        while ((d1 !== g1 || d2 !== g2 || busy) && n < LIMIT) begin
            if (rnd) svc_if.svc_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        check({name, "_timeout"}, int'(n >= LIMIT), 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!svc_if.svc_valid && n < LIMIT) begin
            step();
            n++;
        end
        check({name, "_valid_timeout"}, int'(n >= LIMIT), 0);
    endtask

    task automatic do_reset();
        g1  = 1'b0;
        g2  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_d1"}, int'(d1), 0);
        check({name, "_d2"}, int'(d2), 0);
        check({name, "_valid"}, int'(svc_if.svc_valid), 0);
        check({name, "_ch"}, int'(svc_if.svc_ch), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_err"}, int'(err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int n;
        int bad;
        svc_if.svc_ready = 1'b0;
        step();
        step();
        armed = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_reset_vals("reset");

        // Single grant: full latency from g edge to d toggle.
        svc_if.svc_ready = 1'b1;
        c0 = cyc;
        tog(0);
        n = 0;
        while (d1 == 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("single_latency", cyc - c0, LAT);
        check("single_d2", int'(d2), 0);
        check("single_err", int'(err), 0);
        wait_idle("single", 1'b0);
        check("single_q", exp_q.size(), 0);

        // Backpressure on channel 2.
        svc_if.svc_ready = 1'b0;
        tog(1);
        wait_valid("bp");
        bad = 0;
        repeat (10) begin
            step();
            if (!svc_if.svc_valid || !svc_if.svc_ch || d2) bad++;
        end
        check("bp_stable", bad, 0);
        svc_if.svc_ready = 1'b1;
        c0 = cyc;
        n = 0;
        while (d2 == 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("bp_accept_to_d", cyc - (c0 + 1), HOLD + 1);
        wait_idle("bp", 1'b0);

        // Alternating transitions, each waiting for its done.
        for (int i = 0; i < 6; i++) begin
            tog(i % 2);
            wait_idle("alt", 1'b0);
        end
        check("alt_d1", int'(d1), 0);
        check("alt_d2", int'(d2), 0);
        check("alt_err", int'(err), 0);
        check("alt_q", exp_q.size(), 0);

        // Random legal traffic with random backpressure.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) step();
            tog(int'($urandom_range(0, 1)));
            wait_idle("rand", 1'b1);
        end
        check("rand_err", int'(err), 0);
        check("rand_q", exp_q.size(), 0);

        // Simultaneous grants: ch1 then ch2, error latched.
        svc_if.svc_ready = 1'b1;
        g1 = ~g1;
        g2 = ~g2;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_idle("simul", 1'b0);
        check("simul_err", int'(err), 1);
        repeat (5) step();
        check("simul_err_sticky", int'(err), 1);
        check("simul_q", exp_q.size(), 0);

        do_reset();
        check_reset_vals("rst2");

        // Double transition while offered.
        svc_if.svc_ready = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(0);
        g1 = ~g1;
        wait_valid("dbl");
        g1 = ~g1;
        repeat (SYNC + 2) step();
        check("dbl_err", int'(err), 1);
        check("dbl_still_valid", int'(svc_if.svc_valid), 1);
        svc_if.svc_ready = 1'b1;
        n = 0;
        while (d1 == 1'b0 && n < 50) begin
            step();
            n++;
        end
        check("dbl_diverged", int'(d1 ^ g1), 1);
        wait_idle("dbl", 1'b0);
        check("dbl_q", exp_q.size(), 0);

        // Reset during HOLD drops the service.
        svc_if.svc_ready = 1'b1;
        tog(0);
        wait_valid("rh");
        step();
        check("rh_in_hold", int'(busy && !svc_if.svc_valid), 1);
        do_reset();
        check_reset_vals("rh");
        repeat (HOLD + 4) step();
        check("rh_no_toggle", int'(d1), 0);
        check("rh_idle", int'(busy), 0);
        check("final_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
